// File: rtl/wb_regfile_pkg.sv
// Shared widths and writeback-select encodings for the writeback-stage register file.
package wb_regfile_pkg;

    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam int ADDR_W = $clog2(NREG);
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        WB_SEL_ALU   = 2'b00,
        WB_SEL_MEM   = 2'b01,
        WB_SEL_SHIFT = 2'b10,
        WB_SEL_NONE  = 2'b11
    } wb_sel_t;

endpackage

// File: rtl/wb_scoreboard.sv
// In-flight producer counters per register, with saturation, sticky error flags
// and the RAW stall decision for the two ID source operands.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              dec_en,
    input  logic [ADDR_W-1:0] dec_dest,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_used,
    output logic              stall,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [NREG];
    logic             inc_en;
    logic             rs_hazard;
    logic             rt_hazard;

    assign inc_en = issue && (issue_dest != '0) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                // Simultaneous issue and retire on one register cancel out.
                if (inc_en && issue_dest == ADDR_W'(i) &&
                    !(dec_en && dec_dest == ADDR_W'(i))) begin
                    if (cnt[i] == CNT_MAX) overflow <= 1'b1;
                    else                   cnt[i]   <= cnt[i] + 1'b1;
                end else if (dec_en && dec_dest == ADDR_W'(i) &&
                             !(inc_en && issue_dest == ADDR_W'(i))) begin
                    if (cnt[i] == '0) underflow <= 1'b1;
                    else              cnt[i]    <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // A single outstanding producer that is retiring right now is covered by bypass.
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        if (rs_used && rs_addr != '0)
            rs_hazard = (cnt[rs_addr] > CNT_W'(1)) ||
                        (cnt[rs_addr] == CNT_W'(1) && !(dec_en && dec_dest == rs_addr));
        if (rt_used && rt_addr != '0)
            rt_hazard = (cnt[rt_addr] > CNT_W'(1)) ||
                        (cnt[rt_addr] == CNT_W'(1) && !(dec_en && dec_dest == rt_addr));
    end

    assign stall = rs_hazard || rt_hazard;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: writeback mux, 8x8 storage with r0 hardwired
// to zero, two bypassed read ports and the in-flight scoreboard.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] MEM_WB_mem_out_data,
    input  logic [DATA_W-1:0] MEM_WB_alu_out,
    input  logic [DATA_W-1:0] MEM_WB_shift_out,
    input  logic              MEM_WB_reg_write,
    input  logic [1:0]        MEM_WB_wb_sel,
    input  logic [ADDR_W-1:0] MEM_WB_dest,
    input  logic [ADDR_W-1:0] ID_rs_addr,
    input  logic [ADDR_W-1:0] ID_rt_addr,
    input  logic              ID_rs_used,
    input  logic              ID_rt_used,
    input  logic              ID_issue,
    input  logic [ADDR_W-1:0] ID_issue_dest,
    output logic [DATA_W-1:0] ID_rs_data,
    output logic [DATA_W-1:0] ID_rt_data,
    output logic              ID_stall,
    output logic              WB_write,
    output logic [ADDR_W-1:0] WB_dest,
    output logic [DATA_W-1:0] WB_data,
    output logic              sb_overflow,
    output logic              sb_underflow
);

    logic [DATA_W-1:0] regs [NREG];
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

    always_comb begin
        wb_data = '0;
        case (wb_sel_t'(MEM_WB_wb_sel))
            WB_SEL_ALU:   wb_data = MEM_WB_alu_out;
            WB_SEL_MEM:   wb_data = MEM_WB_mem_out_data;
            WB_SEL_SHIFT: wb_data = MEM_WB_shift_out;
            default:      wb_data = '0;
        endcase
    end

    assign wb_en = MEM_WB_reg_write && (wb_sel_t'(MEM_WB_wb_sel) != WB_SEL_NONE) &&
                   (MEM_WB_dest != '0);

    assign WB_write = wb_en;
    assign WB_dest  = MEM_WB_dest;
    assign WB_data  = wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[MEM_WB_dest] <= wb_data;
        end
    end

    always_comb begin
        ID_rs_data = '0;
        if (ID_rs_addr != '0)
            ID_rs_data = (wb_en && ID_rs_addr == MEM_WB_dest) ? wb_data : regs[ID_rs_addr];
    end

    always_comb begin
        ID_rt_data = '0;
        if (ID_rt_addr != '0)
            ID_rt_data = (wb_en && ID_rt_addr == MEM_WB_dest) ? wb_data : regs[ID_rt_addr];
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue      (ID_issue),
        .issue_dest (ID_issue_dest),
        .dec_en     (wb_en),
        .dec_dest   (MEM_WB_dest),
        .rs_addr    (ID_rs_addr),
        .rs_used    (ID_rs_used),
        .rt_addr    (ID_rt_addr),
        .rt_used    (ID_rt_used),
        .stall      (ID_stall),
        .overflow   (sb_overflow),
        .underflow  (sb_underflow)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a behavioural register/pending-count model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_wb_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_out, alu_out, shift_out;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [2:0] dest;
    logic [2:0] rs_addr, rt_addr;
    logic       rs_used, rt_used;
    logic       issue;
    logic [2:0] issue_dest;
    logic [7:0] rs_data, rt_data;
    logic       stall, wb_write;
    logic [2:0] wb_dest;
    logic [7:0] wb_data;
    logic       ovf, unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                 (clk),
        .reset               (reset),
        .MEM_WB_mem_out_data (mem_out),
        .MEM_WB_alu_out      (alu_out),
        .MEM_WB_shift_out    (shift_out),
        .MEM_WB_reg_write    (reg_write),
        .MEM_WB_wb_sel       (wb_sel),
        .MEM_WB_dest         (dest),
        .ID_rs_addr          (rs_addr),
        .ID_rt_addr          (rt_addr),
        .ID_rs_used          (rs_used),
        .ID_rt_used          (rt_used),
        .ID_issue            (issue),
        .ID_issue_dest       (issue_dest),
        .ID_rs_data          (rs_data),
        .ID_rt_data          (rt_data),
        .ID_stall            (stall),
        .WB_write            (wb_write),
        .WB_dest             (wb_dest),
        .WB_data             (wb_data),
        .sb_overflow         (ovf),
        .sb_underflow        (unf)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural values and number of pending producers.
    int  m_reg [8];
    int  m_pend [8];
    bit  m_ovf, m_unf;
    bit  model_valid = 0;

    function automatic bit m_wb_en();
        return reg_write && wb_sel != 2'd3 && dest != 3'd0;
    endfunction

    function automatic int m_wb_val();
        case (wb_sel)
            2'd0:    return int'(alu_out);
            2'd1:    return int'(mem_out);
            2'd2:    return int'(shift_out);
            default: return 0;
        endcase
    endfunction

    function automatic int m_read(input logic [2:0] a);
        if (a == 0) return 0;
        if (m_wb_en() && dest == a) return m_wb_val();
        return m_reg[a];
    endfunction

    function automatic bit m_hazard(input logic [2:0] a, input logic u);
        int waiting;
        if (!u || a == 0) return 0;
        // Producers still outstanding after this cycle's retirement is accounted for.
        waiting = m_pend[a] - ((m_wb_en() && dest == a) ? 1 : 0);
        return waiting > 0;
    endfunction

    function automatic bit m_stall();
        return m_hazard(rs_addr, rs_used) || m_hazard(rt_addr, rt_used);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) begin m_reg[r] = 0; m_pend[r] = 0; end
            m_ovf = 0; m_unf = 0;
            model_valid = 1;
        end else if (model_valid) begin
            int  nxt;
            bit  inc_ok;
            bit  wen;
            int  wval;
            inc_ok = issue && issue_dest != 0 && !m_stall();
            wen = m_wb_en();
            wval = m_wb_val();
            for (int r = 1; r < 8; r++) begin
                nxt = m_pend[r] + ((inc_ok && issue_dest == r) ? 1 : 0)
                                - ((wen && dest == r) ? 1 : 0);
                if (nxt > 3) begin nxt = 3; m_ovf = 1; end
                if (nxt < 0) begin nxt = 0; m_unf = 1; end
                m_pend[r] = nxt;
            end
            if (wen) m_reg[dest] = wval;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("rs_data",  rs_data,            8'(m_read(rs_addr)));
            check("rt_data",  rt_data,            8'(m_read(rt_addr)));
            check("stall",    {7'd0, stall},      {7'd0, m_stall()});
            check("wb_write", {7'd0, wb_write},   {7'd0, m_wb_en()});
            check("wb_dest",  {5'd0, wb_dest},    {5'd0, dest});
            check("wb_data",  wb_data,            8'(m_wb_val()));
            check("overflow", {7'd0, ovf},        {7'd0, m_ovf});
            check("underflow",{7'd0, unf},        {7'd0, m_unf});
        end
    end

    task automatic idle();
        mem_out = 0; alu_out = 0; shift_out = 0;
        reg_write = 0; wb_sel = 0; dest = 0;
        rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
        issue = 0; issue_dest = 0;
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; advance(); advance(); reset = 0;
    endtask

    task automatic wb(input logic [1:0] sel, input logic [2:0] d, input logic [7:0] v);
        reg_write = 1; wb_sel = sel; dest = d;
        alu_out = v; mem_out = v; shift_out = v;
        if (sel == 2'd0) begin mem_out = ~v; shift_out = v ^ 8'h0F; end
        if (sel == 2'd1) begin alu_out = ~v; shift_out = v ^ 8'h0F; end
        if (sel == 2'd2) begin alu_out = ~v; mem_out = v ^ 8'h0F; end
    endtask

    initial begin
        idle();
        reset = 1;
        advance(); advance();
        reset = 0;

        // Reset state of every register
        for (int i = 1; i < 8; i++) begin
            idle(); rs_addr = 3'(i); rt_addr = 3'(i); rs_used = 1; rt_used = 1;
            settle();
            check("rst_rs", rs_data, 8'h00);
            check("rst_rt", rt_data, 8'h00);
            check("rst_stall", {7'd0, stall}, 8'h00);
            advance();
        end
        check("rst_ovf", {7'd0, ovf}, 8'h00);
        check("rst_unf", {7'd0, unf}, 8'h00);

        // Reserved select and r0 writes: no write, no decrement
        idle(); wb(2'd3, 3'd2, 8'h77); rt_addr = 2;
        settle();
        check("sel11_write", {7'd0, wb_write}, 8'h00);
        check("sel11_data", wb_data, 8'h00);
        check("sel11_rt", rt_data, 8'h00);
        advance();
        idle(); wb(2'd1, 3'd0, 8'hFF); rs_addr = 0; rt_addr = 2;
        settle();
        check("r0_read", rs_data, 8'h00);
        check("r0_write", {7'd0, wb_write}, 8'h00);
        check("r2_kept", rt_data, 8'h00);
        check("no_dec_unf", {7'd0, unf}, 8'h00);
        advance();
        idle(); settle();
        check("no_dec_unf2", {7'd0, unf}, 8'h00);
        advance();

        // Load writeback with same-cycle bypass, then from storage
        idle(); wb(2'd1, 3'd3, 8'hA5); rs_addr = 3;
        settle();
        check("bypass_rs", rs_data, 8'hA5);
        check("bypass_wb", wb_data, 8'hA5);
        advance();
        idle(); rs_addr = 3; rt_addr = 3;
        settle();
        check("stored_rs", rs_data, 8'hA5);
        check("stored_rt", rt_data, 8'hA5);
        check("unf_from_r3", {7'd0, unf}, 8'h01);
        advance();
        idle(); wb(2'd2, 3'd7, 8'h5A); rt_addr = 7;
        settle();
        check("shift_bypass", rt_data, 8'h5A);
        advance();

        // RAW stall and release on writeback
        do_reset();
        idle(); issue = 1; issue_dest = 4;
        settle(); check("issue4_stall", {7'd0, stall}, 8'h00);
        advance();
        idle(); rs_addr = 4; rs_used = 1; issue = 1; issue_dest = 1;
        settle(); check("raw_stall", {7'd0, stall}, 8'h01);
        advance();
        idle(); rs_addr = 4; rs_used = 1; wb(2'd0, 3'd4, 8'h3C);
        settle();
        check("release_stall", {7'd0, stall}, 8'h00);
        check("release_data", rs_data, 8'h3C);
        advance();
        idle(); rt_addr = 1; rt_used = 1;
        settle(); check("stalled_issue_ignored", {7'd0, stall}, 8'h00);
        advance();
        idle(); issue = 1; issue_dest = 4;
        advance();
        idle(); rs_addr = 4; rs_used = 0; rt_addr = 4; rt_used = 0;
        settle(); check("unused_no_stall", {7'd0, stall}, 8'h00);
        advance();
        idle(); rt_addr = 4; rt_used = 1;
        settle(); check("rt_stall", {7'd0, stall}, 8'h01);
        advance();

        // Saturation at three in flight, sticky overflow, then underflow
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(); issue = 1; issue_dest = 5;
            settle();
            check("ovf_before", {7'd0, ovf}, 8'h00);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); settle();
            check("ovf_sticky", {7'd0, ovf}, 8'h01);
            advance();
        end
        idle(); rs_addr = 5; rs_used = 1; wb(2'd0, 3'd5, 8'h01);
        settle(); check("sat3_stall", {7'd0, stall}, 8'h01);
        advance();
        idle(); rs_addr = 5; rs_used = 1; wb(2'd0, 3'd5, 8'h02);
        settle(); check("cnt2_stall", {7'd0, stall}, 8'h01);
        advance();
        idle(); rs_addr = 5; rs_used = 1; wb(2'd0, 3'd5, 8'h03);
        settle();
        check("cnt1_wb_stall", {7'd0, stall}, 8'h00);
        check("cnt1_wb_data", rs_data, 8'h03);
        advance();
        idle(); wb(2'd0, 3'd6, 8'h09);
        settle(); check("unf_before", {7'd0, unf}, 8'h00);
        advance();
        idle(); rt_addr = 6;
        settle();
        check("unf_set", {7'd0, unf}, 8'h01);
        check("r6_written", rt_data, 8'h09);
        advance();

        // Simultaneous issue/retire on r2, then reset overriding both
        do_reset();
        idle(); issue = 1; issue_dest = 2;
        advance();
        idle(); issue = 1; issue_dest = 2; wb(2'd0, 3'd2, 8'h11); rs_addr = 2; rs_used = 1;
        settle(); check("inc_dec_stall", {7'd0, stall}, 8'h00);
        advance();
        idle(); rs_addr = 2; rs_used = 1;
        settle();
        check("cnt_kept_stall", {7'd0, stall}, 8'h01);
        check("r2_value", rs_data, 8'h11);
        advance();
        idle(); reset = 1; issue = 1; issue_dest = 2; wb(2'd0, 3'd2, 8'h22);
        advance();
        reset = 0;
        idle(); rs_addr = 2; rs_used = 1;
        settle();
        check("post_rst_stall", {7'd0, stall}, 8'h00);
        check("post_rst_r2", rs_data, 8'h00);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
